// File: rtl/sd_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_access_arbiter
// Brief    : Two-requester round-robin arbiter sequencing SD card init and
//            single-sector read/write transactions, with timeout and retry.
// Revision : 1.0
// ============================================================================
module sd_access_arbiter #(
  parameter int TIMEOUT    = 1000000,
  parameter int INIT_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_wr,
  input  logic [63:0] req_sec,
  output logic [1:0]  req_ack,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic        sd_init,
  input  logic        init_ok,
  output logic        sd_ren,
  output logic        sd_wen,
  output logic [31:0] sec,
  input  logic        rd_ok,
  input  logic        wr_ok,
  output logic        fifo_busy,
  output logic        sd_ready,
  output logic        sd_fail
);

  localparam int c_CNT_W = $clog2(TIMEOUT + 1);
  localparam int c_RTY_W = $clog2(INIT_RETRY + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_RTY_W-1:0] c_RTY_INIT = c_RTY_W'(INIT_RETRY);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_INIT_WAIT = 3'd1,
    ST_READY     = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT      = 3'd4,
    ST_DONE      = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  state_t               r_state, w_state_nx;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [c_RTY_W-1:0]   r_retry, w_retry_nx;
  logic                 r_last, w_last_nx;
  logic                 r_gnt, w_gnt_nx;
  logic                 r_wr, w_wr_nx;
  logic [31:0]          w_sec_nx;
  logic [1:0]           w_ack_nx, w_done_nx, w_err_nx;
  logic                 w_init_nx, w_ren_nx, w_wen_nx;
  logic                 w_win, w_timeout, w_xfer_ok;

  // Tie goes to the requester that was not granted last.
  assign w_win     = (req_valid == 2'b11) ? ~r_last : req_valid[1];
  assign w_timeout = (r_cnt == c_TO_LAST);
  assign w_xfer_ok = r_wr ? wr_ok : rd_ok;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    w_retry_nx = r_retry;
    w_last_nx  = r_last;
    w_gnt_nx   = r_gnt;
    w_wr_nx    = r_wr;
    w_sec_nx   = sec;
    w_ack_nx   = 2'b00;
    w_done_nx  = 2'b00;
    w_err_nx   = 2'b00;
    w_init_nx  = 1'b0;
    w_ren_nx   = 1'b0;
    w_wen_nx   = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_nx  = 1'b1;
        w_cnt_nx   = '0;
        w_state_nx = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        if (init_ok) begin
          w_state_nx = ST_READY;
        end else if (w_timeout) begin
          if (r_retry > c_RTY_W'(1)) begin
            w_retry_nx = r_retry - 1'b1;
            w_state_nx = ST_INIT;
          end else begin
            w_state_nx = ST_FAIL;
          end
        end
      end
      ST_READY: begin
        if (|req_valid) begin
          w_gnt_nx   = w_win;
          w_last_nx  = w_win;
          w_wr_nx    = req_wr[w_win];
          w_sec_nx   = w_win ? req_sec[63:32] : req_sec[31:0];
          w_state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_ack_nx[r_gnt] = 1'b1;
        w_ren_nx        = ~r_wr;
        w_wen_nx        = r_wr;
        w_cnt_nx        = '0;
        w_state_nx      = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion wins over a coincident timeout.
        if (w_xfer_ok) begin
          w_state_nx = ST_DONE;
        end else if (w_timeout) begin
          w_err_nx[r_gnt] = 1'b1;
          w_retry_nx      = c_RTY_INIT;
          w_state_nx      = ST_INIT;
        end
      end
      ST_DONE: begin
        w_done_nx[r_gnt] = 1'b1;
        w_state_nx       = ST_READY;
      end
      ST_FAIL: begin
        if (|req_valid) begin
          w_ack_nx[w_win] = 1'b1;
          w_err_nx[w_win] = 1'b1;
          w_last_nx       = w_win;
        end
      end
      default: w_state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      r_retry   <= c_RTY_INIT;
      r_last    <= 1'b1;
      r_gnt     <= 1'b0;
      r_wr      <= 1'b0;
      sec       <= '0;
      req_ack   <= '0;
      req_done  <= '0;
      req_err   <= '0;
      sd_init   <= 1'b0;
      sd_ren    <= 1'b0;
      sd_wen    <= 1'b0;
      fifo_busy <= 1'b0;
      sd_ready  <= 1'b0;
      sd_fail   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_retry   <= w_retry_nx;
      r_last    <= w_last_nx;
      r_gnt     <= w_gnt_nx;
      r_wr      <= w_wr_nx;
      sec       <= w_sec_nx;
      req_ack   <= w_ack_nx;
      req_done  <= w_done_nx;
      req_err   <= w_err_nx;
      sd_init   <= w_init_nx;
      sd_ren    <= w_ren_nx;
      sd_wen    <= w_wen_nx;
      // Status levels track the state being entered so they align with it.
      fifo_busy <= (w_state_nx == ST_ISSUE) || (w_state_nx == ST_WAIT) ||
                   (w_state_nx == ST_DONE);
      sd_ready  <= (w_state_nx == ST_READY);
      sd_fail   <= (w_state_nx == ST_FAIL);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_access_arbiter
// Brief    : Directed self-checking bench for sd_access_arbiter (TIMEOUT=16).
// Revision : 1.0
// ============================================================================
module tb_sd_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_wr = '0;
  logic [63:0] req_sec = '0;
  logic [1:0]  req_ack, req_done, req_err;
  logic        sd_init, sd_ren, sd_wen, fifo_busy, sd_ready, sd_fail;
  logic        init_ok = 1'b0, rd_ok = 1'b0, wr_ok = 1'b0;
  logic [31:0] sec;

  int nvec = 0;
  int nerr = 0;

  sd_access_arbiter #(.TIMEOUT(16), .INIT_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
    .req_sec(req_sec), .req_ack(req_ack), .req_done(req_done),
    .req_err(req_err), .sd_init(sd_init), .init_ok(init_ok),
    .sd_ren(sd_ren), .sd_wen(sd_wen), .sec(sec), .rd_ok(rd_ok),
    .wr_ok(wr_ok), .fifo_busy(fifo_busy), .sd_ready(sd_ready),
    .sd_fail(sd_fail)
  );

  always #5 clk = ~clk;

  wire [43:0] all_outs = {req_ack, req_done, req_err, sd_init, sd_ren, sd_wen,
                          sec, fifo_busy, sd_ready, sd_fail};

  task automatic bring_up();
    bit ok = 0;
    rst_n = 1'b0; req_valid = '0; req_wr = '0; req_sec = '0;
    init_ok = 1'b0; rd_ok = 1'b0; wr_ok = 1'b0;
    repeat (2) @(negedge clk);
    init_ok = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sd_ready) begin ok = 1; break; end
    end
    init_ok = 1'b0;
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL bring_up: sd_ready=%0b required 1 within 10 cycles", sd_ready);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nvec++;
    if (all_outs !== 44'h0) begin
      nerr++; $display("FAIL reset_outputs: got %h required 0", all_outs);
    end
  endtask

  task automatic test_init();
    int pulses = 0;
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (sd_init === 1'b1) pulses++;
      if (c == 1) begin
        nvec++;
        if (sd_init !== 1'b1) begin nerr++; $display("FAIL init_strobe: got %b required 1", sd_init); end
      end
      if (c == 6) begin
        nvec++;
        if (sd_ready !== 1'b0) begin nerr++; $display("FAIL init_not_ready_c6: got %b required 0", sd_ready); end
        init_ok = 1'b1;
      end
      if (c == 7) begin
        nvec++;
        if (sd_ready !== 1'b1) begin nerr++; $display("FAIL init_ready_c7: got %b required 1", sd_ready); end
        init_ok = 1'b0;
      end
    end
    nvec++;
    if (pulses != 1) begin nerr++; $display("FAIL init_pulse_count: got %0d required 1", pulses); end
  endtask

  task automatic test_read();
    req_valid = 2'b01; req_wr = 2'b00; req_sec = {32'h0BAD_F00D, 32'h0000_1234};
    @(negedge clk);
    nvec++;
    if ({req_ack, sd_ren, fifo_busy, sd_ready, sec} !== {2'b00, 1'b0, 1'b1, 1'b0, 32'h1234}) begin
      nerr++; $display("FAIL read_issue: got ack=%b ren=%b busy=%b rdy=%b sec=%h required 00 0 1 0 00001234",
                       req_ack, sd_ren, fifo_busy, sd_ready, sec);
    end
    @(negedge clk);
    nvec++;
    if ({req_ack, sd_ren, sd_wen, sec} !== {2'b01, 1'b1, 1'b0, 32'h1234}) begin
      nerr++; $display("FAIL read_ack: got ack=%b ren=%b wen=%b sec=%h required 01 1 0 00001234",
                       req_ack, sd_ren, sd_wen, sec);
    end
    req_valid = 2'b00; wr_ok = 1'b1;
    @(negedge clk);
    nvec++;
    if ({req_ack, sd_ren, req_done, fifo_busy} !== {2'b00, 1'b0, 2'b00, 1'b1}) begin
      nerr++; $display("FAIL read_one_cycle: got ack=%b ren=%b done=%b busy=%b required 00 0 00 1",
                       req_ack, sd_ren, req_done, fifo_busy);
    end
    wr_ok = 1'b0;
    @(negedge clk);
    nvec++;
    if ({req_done, fifo_busy} !== {2'b00, 1'b1}) begin
      nerr++; $display("FAIL read_ignores_wr_ok: got done=%b busy=%b required 00 1", req_done, fifo_busy);
    end
    rd_ok = 1'b1;
    @(negedge clk);
    rd_ok = 1'b0;
    nvec++;
    if ({req_done, fifo_busy, sec} !== {2'b00, 1'b1, 32'h1234}) begin
      nerr++; $display("FAIL read_done_state: got done=%b busy=%b sec=%h required 00 1 00001234",
                       req_done, fifo_busy, sec);
    end
    @(negedge clk);
    nvec++;
    if ({req_done, sd_ready, fifo_busy} !== {2'b01, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL read_done_pulse: got done=%b rdy=%b busy=%b required 01 1 0",
                       req_done, sd_ready, fifo_busy);
    end
    @(negedge clk);
    nvec++;
    if (req_done !== 2'b00) begin nerr++; $display("FAIL read_done_clear: got %b required 00", req_done); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp;
    logic [31:0] exp_sec;
    bit got;
    bring_up();
    req_valid = 2'b11; req_wr = 2'b11; req_sec = {32'h0000_2222, 32'h0000_1111};
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_sec = (k % 2 == 0) ? 32'h1111 : 32'h2222;
      got = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (req_ack !== 2'b00) begin got = 1; break; end
      end
      nvec++;
      if (!got || {req_ack, sd_wen, sd_ren, sec} !== {exp, 1'b1, 1'b0, exp_sec}) begin
        nerr++; $display("FAIL rr_grant%0d: got ack=%b wen=%b ren=%b sec=%h required %b 1 0 %h",
                         k, req_ack, sd_wen, sd_ren, sec, exp, exp_sec);
      end
      rd_ok = 1'b1;
      @(negedge clk);
      rd_ok = 1'b0;
      nvec++;
      if ({req_done, fifo_busy} !== {2'b00, 1'b1}) begin
        nerr++; $display("FAIL rr_ignores_rd_ok%0d: got done=%b busy=%b required 00 1", k, req_done, fifo_busy);
      end
      wr_ok = 1'b1;
      @(negedge clk);
      wr_ok = 1'b0;
      @(negedge clk);
      if (k == 3) req_valid = 2'b00;
      nvec++;
      if (req_done !== exp) begin
        nerr++; $display("FAIL rr_done%0d: got %b required %b", k, req_done, exp);
      end
    end
  endtask

  task automatic test_timeout();
    int  err_at = 0;
    logic [1:0] err_val = '0;
    bit got = 0;
    bit seen_init = 0;
    req_valid = 2'b10; req_wr = 2'b00; req_sec = {32'h0000_ABCD, 32'h0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_ack !== 2'b00) begin got = 1; break; end
    end
    req_valid = 2'b00;
    nvec++;
    if (!got || {req_ack, sd_ren, sec} !== {2'b10, 1'b1, 32'hABCD}) begin
      nerr++; $display("FAIL to_strobe: got ack=%b ren=%b sec=%h required 10 1 0000abcd", req_ack, sd_ren, sec);
    end
    for (int j = 1; j <= 17; j++) begin
      @(negedge clk);
      if (req_err !== 2'b00 && err_at == 0) begin err_at = j; err_val = req_err; end
      if (req_done !== 2'b00) err_at = -1;
      if (j == 17) seen_init = (sd_init === 1'b1);
    end
    nvec++;
    if (err_at != 16 || err_val !== 2'b10) begin
      nerr++; $display("FAIL to_err: got cycle=%0d err=%b required cycle=16 err=10", err_at, err_val);
    end
    nvec++;
    if (!seen_init) begin nerr++; $display("FAIL to_reinit: got sd_init=0 required 1 at cycle 17"); end
    init_ok = 1'b1;
    @(negedge clk);
    init_ok = 1'b0;
  endtask

  task automatic test_init_fail();
    int pulses = 0;
    int fail_at = 0;
    logic strobes = 1'b0;
    rst_n = 1'b0; init_ok = 1'b0; req_valid = '0; req_wr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (sd_init === 1'b1) pulses++;
      if (sd_fail === 1'b1 && fail_at == 0) fail_at = c;
    end
    nvec++;
    if (pulses != 3 || fail_at != 51) begin
      nerr++; $display("FAIL fail_entry: got pulses=%0d fail_cycle=%0d required 3 51", pulses, fail_at);
    end
    req_valid = 2'b01;
    @(negedge clk);
    nvec++;
    if ({req_ack, req_err, sd_ren, sd_wen, sd_fail, sd_ready} !== {2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL fail_answer0: got ack=%b err=%b ren=%b wen=%b fail=%b rdy=%b required 01 01 0 0 1 0",
                       req_ack, req_err, sd_ren, sd_wen, sd_fail, sd_ready);
    end
    req_valid = 2'b11;
    @(negedge clk);
    nvec++;
    if ({req_ack, req_err} !== {2'b10, 2'b10}) begin
      nerr++; $display("FAIL fail_tie1: got ack=%b err=%b required 10 10", req_ack, req_err);
    end
    @(negedge clk);
    req_valid = 2'b00;
    nvec++;
    if ({req_ack, req_err} !== {2'b01, 2'b01}) begin
      nerr++; $display("FAIL fail_tie2: got ack=%b err=%b required 01 01", req_ack, req_err);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      strobes = strobes | sd_ren | sd_wen | sd_init | (|req_ack);
    end
    nvec++;
    if (strobes !== 1'b0 || sd_fail !== 1'b1) begin
      nerr++; $display("FAIL fail_quiet: got strobes=%b fail=%b required 0 1", strobes, sd_fail);
    end
  endtask

  task automatic test_reset_mid();
    bit got = 0;
    logic [1:0] resp = '0;
    bring_up();
    req_valid = 2'b01; req_wr = 2'b00; req_sec = {32'h0, 32'h0000_0055};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_ack !== 2'b00) begin got = 1; break; end
    end
    req_valid = 2'b00;
    nvec++;
    if (!got || fifo_busy !== 1'b1) begin
      nerr++; $display("FAIL mid_setup: got ack_seen=%0b busy=%b required 1 1", got, fifo_busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nvec++;
    if (all_outs !== 44'h0) begin nerr++; $display("FAIL mid_async_clear: got %h required 0", all_outs); end
    rd_ok = 1'b1;
    repeat (2) @(negedge clk);
    rd_ok = 1'b0;
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      resp = resp | req_done | req_err;
      if (c == 1) begin
        nvec++;
        if ({sd_init, fifo_busy} !== 2'b10) begin
          nerr++; $display("FAIL mid_reinit: got sd_init=%b busy=%b required 1 0", sd_init, fifo_busy);
        end
      end
    end
    nvec++;
    if (resp !== 2'b00) begin nerr++; $display("FAIL mid_no_response: got %b required 00", resp); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_back_to_back();
    test_timeout();
    test_init_fail();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
